ddr_dqs_tx_strobe_gen: RTL

- Write-direction DQS strobe generator: the transmit-side counterpart of the DQS receive path in the DQ byte.
- Accepts one write-burst request at a time through a valid/ready handshake.
- Produces the per-clock, two-phase DQS_t/DQS_c pattern and the driver output-enable: static preamble, toggling preamble, burst toggle, toggling postamble.
- Feeds the DQS TX serializer and pad driver. Software override forces a static DQS level for calibration and test.

---
 rtl/ddr_dqs_tx_strobe_gen.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_dqs_tx_strobe_gen.sv
// Write-direction DQS strobe generator: turns one accepted write-burst request into the
// per-clock two-phase DQS_t/DQS_c pattern plus driver enable (preamble, burst, postamble).
module ddr_dqs_tx_strobe_gen #(
   parameter int CNTW = 6,
   parameter int PLW  = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_wr_vld,
   output logic            o_wr_rdy,
   input  logic [CNTW-1:0] i_wr_len,
   input  logic [PLW-1:0]  i_pre_static,
   input  logic [PLW-1:0]  i_pre_tgl,
   input  logic [PLW-1:0]  i_post_len,
   input  logic            i_sw_ovr,
   input  logic            i_sw_val,
   output logic [1:0]      o_dqs_t,
   output logic [1:0]      o_dqs_c,
   output logic            o_oe,
   output logic            o_busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_PRE_S  = 3'd2,
      ST_PRE_T  = 3'd3,
      ST_BURST  = 3'd4,
      ST_POST   = 3'd5
   } state_t;

   localparam logic [1:0] PAT_STATIC_T = 2'b00;
   localparam logic [1:0] PAT_TOGGLE_T = 2'b01;

   // Length fields count clocks; the counter holds clocks remaining after the current one.
   function automatic logic [CNTW-1:0] fld_m1(input logic [PLW-1:0] fld);
      return CNTW'(fld) - CNTW'(1'b1);
   endfunction

   function automatic logic [CNTW-1:0] len_m1(input logic [CNTW-1:0] len);
      logic [CNTW-1:0] res;
      if (len == {CNTW{1'b0}}) begin
         res = {CNTW{1'b0}};
      end else begin
         res = len - CNTW'(1'b1);
      end
      return res;
   endfunction

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CNTW-1:0] len_q, len_d;
   logic [PLW-1:0]  pre_s_q, pre_s_d;
   logic [PLW-1:0]  pre_t_q, pre_t_d;
   logic [PLW-1:0]  post_q, post_d;
   logic [1:0]      dqs_t_q, dqs_t_d;
   logic [1:0]      dqs_c_q, dqs_c_d;
   logic            oe_q, oe_d;
   logic            rdy_q, rdy_d;
   logic            busy_q, busy_d;
   logic            accept_s;
   logic            cnt_zero_s;

   assign accept_s   = i_wr_vld & rdy_q & ~i_sw_ovr;
   assign cnt_zero_s = (cnt_q == {CNTW{1'b0}});

   // Next-state, counter and request-field latching.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      pre_s_d = pre_s_q;
      pre_t_d = pre_t_q;
      post_d  = post_q;
      if (i_sw_ovr) begin
         state_d = ST_IDLE;
         cnt_d   = {CNTW{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  len_d   = i_wr_len;
                  pre_s_d = i_pre_static;
                  pre_t_d = i_pre_tgl;
                  post_d  = i_post_len;
                  state_d = ST_LAUNCH;
                  cnt_d   = {CNTW{1'b0}};
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = {CNTW{1'b0}};
               end
            end
            // One registered stage between accept and the first strobe clock.
            ST_LAUNCH: begin
               if (pre_s_q != {PLW{1'b0}}) begin
                  state_d = ST_PRE_S;
                  cnt_d   = fld_m1(pre_s_q);
               end else if (pre_t_q != {PLW{1'b0}}) begin
                  state_d = ST_PRE_T;
                  cnt_d   = fld_m1(pre_t_q);
               end else begin
                  state_d = ST_BURST;
                  cnt_d   = len_m1(len_q);
               end
            end
            ST_PRE_S: begin
               if (!cnt_zero_s) begin
                  cnt_d = cnt_q - CNTW'(1'b1);
               end else if (pre_t_q != {PLW{1'b0}}) begin
                  state_d = ST_PRE_T;
                  cnt_d   = fld_m1(pre_t_q);
               end else begin
                  state_d = ST_BURST;
                  cnt_d   = len_m1(len_q);
               end
            end
            ST_PRE_T: begin
               if (!cnt_zero_s) begin
                  cnt_d = cnt_q - CNTW'(1'b1);
               end else begin
                  state_d = ST_BURST;
                  cnt_d   = len_m1(len_q);
               end
            end
            ST_BURST: begin
               if (!cnt_zero_s) begin
                  cnt_d = cnt_q - CNTW'(1'b1);
               end else if (accept_s) begin
                  // Seamless follow-on burst: no pre/postamble between the two.
                  len_d   = i_wr_len;
                  pre_s_d = i_pre_static;
                  pre_t_d = i_pre_tgl;
                  post_d  = i_post_len;
                  state_d = ST_BURST;
                  cnt_d   = len_m1(i_wr_len);
               end else if (post_q != {PLW{1'b0}}) begin
                  state_d = ST_POST;
                  cnt_d   = fld_m1(post_q);
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = {CNTW{1'b0}};
               end
            end
            ST_POST: begin
               if (!cnt_zero_s) begin
                  cnt_d = cnt_q - CNTW'(1'b1);
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = {CNTW{1'b0}};
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = {CNTW{1'b0}};
            end
         endcase
      end
   end

   // Output decode from the next state so every output is a flop aligned with state_q.
   always_comb begin
      dqs_t_d = PAT_STATIC_T;
      oe_d    = 1'b0;
      case (state_d)
         ST_IDLE, ST_LAUNCH: begin
            dqs_t_d = PAT_STATIC_T;
            oe_d    = 1'b0;
         end
         ST_PRE_S: begin
            dqs_t_d = PAT_STATIC_T;
            oe_d    = 1'b1;
         end
         ST_PRE_T, ST_BURST, ST_POST: begin
            dqs_t_d = PAT_TOGGLE_T;
            oe_d    = 1'b1;
         end
         default: begin
            dqs_t_d = PAT_STATIC_T;
            oe_d    = 1'b0;
         end
      endcase
      rdy_d  = (state_d == ST_IDLE) |
               ((state_d == ST_BURST) & (cnt_d == {CNTW{1'b0}}));
      busy_d = (state_d != ST_IDLE);
      if (i_sw_ovr) begin
         dqs_t_d = {2{i_sw_val}};
         oe_d    = 1'b1;
         rdy_d   = 1'b0;
         busy_d  = 1'b0;
      end else begin
         busy_d  = (state_d != ST_IDLE);
      end
      dqs_c_d = ~dqs_t_d;
   end

   // State, counter and latched request fields.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNTW{1'b0}};
         len_q   <= {CNTW{1'b0}};
         pre_s_q <= {PLW{1'b0}};
         pre_t_q <= {PLW{1'b0}};
         post_q  <= {PLW{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         pre_s_q <= pre_s_d;
         pre_t_q <= pre_t_d;
         post_q  <= post_d;
      end
   end

   // Registered outputs; reset drops the driver enable immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dqs_t_q <= 2'b00;
         dqs_c_q <= 2'b11;
         oe_q    <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         dqs_t_q <= dqs_t_d;
         dqs_c_q <= dqs_c_d;
         oe_q    <= oe_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   assign o_dqs_t  = dqs_t_q;
   assign o_dqs_c  = dqs_c_q;
   assign o_oe     = oe_q;
   assign o_wr_rdy = rdy_q;
   assign o_busy   = busy_q;

endmodule
